apmu_irq_x_ctrl: RTL

External-interrupt controller driving the core's 32-line `irq_x` interface and consuming its `irq_x_ack_o`/`irq_x_ack_id_o` acknowledge. It sits beside `ibex_pmu_core`, typically fed by APMU performance-event overflow lines and other SoC sources. Per source it provides:
- synchronisation of the asynchronous source line;
- level or edge gating and a pending latch;
- an enable mask;
- overrun detection.

Software configures it through a single-cycle register port.

---
 rtl/apmu_ibex_pkg.sv | 17 +
 rtl/apmu_irq_x_gateway.sv | 76 +++++++
 rtl/apmu_irq_x_ctrl.sv | 99 +++++++++
 3 files changed

// File: rtl/apmu_ibex_pkg.sv
// Purpose: shared constants and register map of the external-interrupt controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package apmu_ibex_pkg;

  // Width of the core's irq_x interface.
  localparam int unsigned IrqXNum = 32;

  // Register index on the cfg port.
  typedef enum logic [1:0] {
    IRQX_ENABLE  = 2'd0,
    IRQX_TRIGGER = 2'd1,
    IRQX_PENDING = 2'd2,
    IRQX_OVERRUN = 2'd3
  } irqx_reg_e;

endpackage

// File: rtl/apmu_irq_x_gateway.sv
// Purpose: per-source synchroniser, edge history, pending latch and overrun flag.
// Latency: src_i high sampled at edge 0 -> pending after edge SyncStages+1 (level or edge mode).
// Backpressure: none; an edge arriving while pending is recorded in overrun.
//
// Ports: src_i raw async line; trigger 1=edge 0=level (current setting);
//   ack_hit core acknowledged this source; sw_set software trigger (edge only);
//   ovr_clr write-1-clear of overrun; mode_chg trigger bit changes this edge;
//   pending / overrun registered state.
module apmu_irq_x_gateway #(
  parameter int unsigned SyncStages = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic src_i,
  input  logic trigger,
  input  logic ack_hit,
  input  logic sw_set,
  input  logic ovr_clr,
  input  logic mode_chg,
  output logic pending,
  output logic overrun
);

  logic [SyncStages-1:0] sync_q;
  logic                  lvl_q;      // synchronised level
  logic                  hist_q;     // previous synchronised level (edge history)
  logic                  pending_q;
  logic                  overrun_q;
  logic                  rise;
  logic                  ovr_set;

  assign rise = lvl_q & ~hist_q;

  // Overrun only exists for edge sources; a same-edge ack consumes the old
  // request so the new edge simply re-arms pending.
  assign ovr_set = trigger & rise & pending_q & ~ack_hit;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q    <= '0;
      lvl_q     <= 1'b0;
      hist_q    <= 1'b0;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (SyncStages > 1) begin
        sync_q <= {sync_q[SyncStages-2:0], src_i};
      end else begin
        sync_q <= src_i;
      end
      lvl_q  <= sync_q[SyncStages-1];
      // History keeps running across mode changes so no false edge appears.
      hist_q <= lvl_q;

      if (mode_chg) begin
        pending_q <= 1'b0;
      end else if (trigger) begin
        // Sets beat the ack clear.
        if (rise || sw_set) begin
          pending_q <= 1'b1;
        end else if (ack_hit) begin
          pending_q <= 1'b0;
        end
      end else begin
        pending_q <= lvl_q;
      end

      // A new overrun wins over a same-edge clear.
      overrun_q <= ovr_set | (overrun_q & ~ovr_clr);
    end
  end

  assign pending = pending_q;
  assign overrun = overrun_q;

endmodule

// File: rtl/apmu_irq_x_ctrl.sv
// Purpose: external-interrupt controller feeding the core irq_x lines, with cfg register port.
// Latency: source -> irq_x_o after edge SyncStages+1; cfg read data one cycle after request.
// Backpressure: none; cfg accepts a request every cycle, ack is never stalled.
//
// Ports: src_i raw sources; irq_x_o = pending & enable (zero-extended);
//   irq_x_ack_i / irq_x_ack_id_i core acknowledge; cfg_req_i/we_i/addr_i/wdata_i
//   register access; cfg_rvalid_o / cfg_rdata_o registered response.
module apmu_irq_x_ctrl
  import apmu_ibex_pkg::*;
#(
  parameter int unsigned NumSrc     = 32,
  parameter int unsigned SyncStages = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [NumSrc-1:0]   src_i,
  output logic [IrqXNum-1:0]  irq_x_o,
  input  logic                irq_x_ack_i,
  input  logic [4:0]          irq_x_ack_id_i,
  input  logic                cfg_req_i,
  input  logic                cfg_we_i,
  input  logic [1:0]          cfg_addr_i,
  input  logic [31:0]         cfg_wdata_i,
  output logic                cfg_rvalid_o,
  output logic [31:0]         cfg_rdata_o
);

  logic [NumSrc-1:0] enable_q;
  logic [NumSrc-1:0] trigger_q;
  logic [NumSrc-1:0] pending;
  logic [NumSrc-1:0] overrun;
  logic [NumSrc-1:0] ack_hit;
  logic [NumSrc-1:0] sw_set;
  logic [NumSrc-1:0] ovr_clr;
  logic [NumSrc-1:0] mode_chg;
  logic [NumSrc-1:0] wdata;
  logic [NumSrc-1:0] rd_mux;
  logic              wr;
  logic              rd;

  // Bits at or above NumSrc do not exist, so their write data is dropped here.
  assign wdata = cfg_wdata_i[NumSrc-1:0];
  assign wr    = cfg_req_i & cfg_we_i;
  assign rd    = cfg_req_i & ~cfg_we_i;

  // Software set is only honoured for edge sources.
  assign sw_set   = (wr && cfg_addr_i == IRQX_PENDING) ? (wdata & trigger_q) : '0;
  assign ovr_clr  = (wr && cfg_addr_i == IRQX_OVERRUN) ? wdata : '0;
  assign mode_chg = (wr && cfg_addr_i == IRQX_TRIGGER) ? (wdata ^ trigger_q) : '0;

  for (genvar i = 0; i < NumSrc; i++) begin : g_src
    // Ids at or above NumSrc match no gateway and are dropped.
    assign ack_hit[i] = irq_x_ack_i && (irq_x_ack_id_i == 5'(i));

    apmu_irq_x_gateway #(
      .SyncStages (SyncStages)
    ) u_gw (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .src_i    (src_i[i]),
      .trigger  (trigger_q[i]),
      .ack_hit  (ack_hit[i]),
      .sw_set   (sw_set[i]),
      .ovr_clr  (ovr_clr[i]),
      .mode_chg (mode_chg[i]),
      .pending  (pending[i]),
      .overrun  (overrun[i])
    );
  end

  always_comb begin
    rd_mux = '0;
    unique case (irqx_reg_e'(cfg_addr_i))
      IRQX_ENABLE:  rd_mux = enable_q;
      IRQX_TRIGGER: rd_mux = trigger_q;
      IRQX_PENDING: rd_mux = pending;
      IRQX_OVERRUN: rd_mux = overrun;
      default:      rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      enable_q     <= '0;
      trigger_q    <= '0;
      cfg_rvalid_o <= 1'b0;
      cfg_rdata_o  <= '0;
    end else begin
      if (wr && cfg_addr_i == IRQX_ENABLE)  enable_q  <= wdata;
      if (wr && cfg_addr_i == IRQX_TRIGGER) trigger_q <= wdata;
      cfg_rvalid_o <= cfg_req_i;
      // Reads return the value before this access; writes return zero.
      cfg_rdata_o  <= rd ? 32'(rd_mux) : 32'd0;
    end
  end

  assign irq_x_o = IrqXNum'(pending & enable_q);

endmodule
